// File: rtl/rotary_enc.sv
// rotary_enc: quadrature encoder decoder for the panel rotary selector.
// enc_a, enc_b and enc_sw are synchronized and debounced. A debounced
// falling edge on A steps a one-hot position by +1 (B high) or -1 (B low).
// A debounced press of the push button yields a one-cycle strobe.
// Define ROTARY_WRAP_EN to make the position wrap at the ends. Without it,
// the position saturates at the ends.

// One input channel: two-flop synchronizer followed by a counting debouncer.
module rotary_enc_chan #(
    parameter logic [15:0] DEBOUNCE = 16'd50000
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic din,
    output logic level
);

    logic        meta_q, meta_d;
    logic        sync_q, sync_d;
    logic        db_q,   db_d;
    logic [15:0] cnt_q,  cnt_d;

    // Synchronizer shift and debounce counter next-state.
    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        db_d   = db_q;
        cnt_d  = '0;
        if (sync_q != db_q) begin
            if (cnt_q == DEBOUNCE - 16'd1) begin
                db_d  = ~db_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // Channel state registers; reset to the idle-high level.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            db_q   <= 1'b1;
            cnt_q  <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end

    assign level = db_q;

endmodule

module rotary_enc #(
    parameter logic [15:0] DEBOUNCE  = 16'd50000,
    parameter int          POSITIONS = 11
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        enc_a,
    input  logic        enc_b,
    input  logic        enc_sw,
    output logic [10:0] rotary_bus,
    output logic        moved,
    output logic        sw_press
);

    localparam logic [3:0] POS_MAX = 4'(POSITIONS - 1);

    logic       a_db, b_db, sw_db;
    logic       a_prev_q, a_prev_d;
    logic       sw_prev_q, sw_prev_d;
    logic       a_fall, sw_fall;
    logic [3:0] pos_q, pos_d;
    logic       moved_q, moved_d;
    logic       sw_press_q, sw_press_d;

    rotary_enc_chan #(.DEBOUNCE(DEBOUNCE)) u_chan_a (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .din     (enc_a),
        .level   (a_db)
    );

    rotary_enc_chan #(.DEBOUNCE(DEBOUNCE)) u_chan_b (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .din     (enc_b),
        .level   (b_db)
    );

    rotary_enc_chan #(.DEBOUNCE(DEBOUNCE)) u_chan_sw (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .din     (enc_sw),
        .level   (sw_db)
    );

    // Falling-edge detection on the debounced A and push-button levels.
    always_comb begin
        a_prev_d  = a_db;
        sw_prev_d = sw_db;
        a_fall    = a_prev_q & ~a_db;
        sw_fall   = sw_prev_q & ~sw_db;
    end

    // Position stepping; moved is raised only when pos actually changes.
    always_comb begin
        pos_d   = pos_q;
        moved_d = 1'b0;
        if (a_fall) begin
            if (b_db) begin
                if (pos_q != POS_MAX) begin
                    pos_d   = pos_q + 4'd1;
                    moved_d = 1'b1;
                end
`ifdef ROTARY_WRAP_EN
                else begin
                    pos_d   = '0;
                    moved_d = 1'b1;
                end
`endif
            end else begin
                if (pos_q != '0) begin
                    pos_d   = pos_q - 4'd1;
                    moved_d = 1'b1;
                end
`ifdef ROTARY_WRAP_EN
                else begin
                    pos_d   = POS_MAX;
                    moved_d = 1'b1;
                end
`endif
            end
        end
    end

    // Press strobe follows the debounced button falling edge.
    always_comb begin
        sw_press_d = sw_fall;
    end

    // Edge-history, position and strobe registers.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            a_prev_q   <= 1'b1;
            sw_prev_q  <= 1'b1;
            pos_q      <= '0;
            moved_q    <= 1'b0;
            sw_press_q <= 1'b0;
        end else begin
            a_prev_q   <= a_prev_d;
            sw_prev_q  <= sw_prev_d;
            pos_q      <= pos_d;
            moved_q    <= moved_d;
            sw_press_q <= sw_press_d;
        end
    end

    // One-hot decode of the registered position.
    always_comb begin
        rotary_bus = 11'd1 << pos_q;
    end

    assign moved    = moved_q;
    assign sw_press = sw_press_q;

endmodule

// File: tb/tb_rotary_enc.sv
// Testbench for rotary_enc with DEBOUNCE=4, POSITIONS=11.
// Expected moved/sw_press strobes are queued with their due cycle when the
// stimulus is driven and are matched by a negedge monitor.
module tb_rotary_enc;

    localparam logic [15:0] DEB = 16'd4;
    localparam int          POS = 11;
    // input -> 2 sync flops -> DEBOUNCE differing samples -> output register
    localparam int          LAT = 2 + 4 + 1;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    logic        enc_a   = 1'b1;
    logic        enc_b   = 1'b1;
    logic        enc_sw  = 1'b1;
    logic [10:0] rotary_bus;
    logic        moved;
    logic        sw_press;

    rotary_enc #(.DEBOUNCE(DEB), .POSITIONS(POS)) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .enc_sw     (enc_sw),
        .rotary_bus (rotary_bus),
        .moved      (moved),
        .sw_press   (sw_press)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        logic [10:0] bus;
        int          due;
    } ev_t;

    typedef struct {
        bit          cw;
        logic [10:0] bus;
        bit          mv;
    } vec_t;

    ev_t  mv_q[$];
    int   sw_q[$];
    ev_t  ev;
    int   sw_due;
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;
    vec_t vt[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every strobe must match a queued expectation.
    always @(negedge clk_sys) begin
        if (mon_en) begin
            check("onehot", 32'($onehot(rotary_bus)), 32'd1);
            if (moved) begin
                total++;
                if (mv_q.size() == 0) begin
                    bad++;
                    $display("FAIL moved_unexpected: got strobe at cycle %0d bus %0h, expected none", cyc, rotary_bus);
                end else begin
                    ev = mv_q.pop_front();
                    if (rotary_bus !== ev.bus || cyc != ev.due) begin
                        bad++;
                        $display("FAIL moved: got bus %0h cycle %0d, expected bus %0h cycle %0d",
                                 rotary_bus, cyc, ev.bus, ev.due);
                    end
                end
            end
            if (mv_q.size() > 0 && cyc > mv_q[0].due) begin
                total++;
                bad++;
                $display("FAIL moved_missing: got no strobe by cycle %0d, expected one at %0d", cyc, mv_q[0].due);
                void'(mv_q.pop_front());
            end
            if (sw_press) begin
                total++;
                if (sw_q.size() == 0) begin
                    bad++;
                    $display("FAIL press_unexpected: got strobe at cycle %0d, expected none", cyc);
                end else begin
                    sw_due = sw_q.pop_front();
                    if (cyc != sw_due) begin
                        bad++;
                        $display("FAIL press: got strobe at cycle %0d, expected cycle %0d", cyc, sw_due);
                    end
                end
            end
            if (sw_q.size() > 0 && cyc > sw_q[0]) begin
                total++;
                bad++;
                $display("FAIL press_missing: got no strobe by cycle %0d, expected one at %0d", cyc, sw_q[0]);
                void'(sw_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        tick(n);
        check("rst_bus", 32'(rotary_bus), 32'h001);
        check("rst_moved", 32'(moved), 32'd0);
        check("rst_press", 32'(sw_press), 32'd0);
        rst_n = 1'b1;
        tick(5);
    endtask

    task automatic set_dir(input bit cw);
        enc_b = cw;
        tick(12);
    endtask

    task automatic detent(input logic [10:0] exp_bus, input bit mv);
        enc_a = 1'b0;
        if (mv) mv_q.push_back('{exp_bus, cyc + LAT});
        tick(10);
        enc_a = 1'b1;
        tick(15);
        check("detent_bus", 32'(rotary_bus), 32'(exp_bus));
    endtask

    initial begin
        vt[0] = '{1'b1, 11'h002, 1'b1};
        vt[1] = '{1'b1, 11'h004, 1'b1};
        vt[2] = '{1'b1, 11'h008, 1'b1};
        vt[3] = '{1'b0, 11'h004, 1'b1};
        vt[4] = '{1'b0, 11'h002, 1'b1};
        vt[5] = '{1'b0, 11'h001, 1'b1};
`ifdef ROTARY_WRAP_EN
        vt[6] = '{1'b0, 11'h400, 1'b1};
`else
        vt[6] = '{1'b0, 11'h001, 1'b0};
`endif

        // Reset state and idle period
        tick(3);
        check("rst_bus", 32'(rotary_bus), 32'h001);
        check("rst_moved", 32'(moved), 32'd0);
        check("rst_press", 32'(sw_press), 32'd0);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        tick(100);
        check("idle_bus", 32'(rotary_bus), 32'h001);

        // Table: CW detents, CCW back to 0, CCW at the low end
        for (int i = 0; i < 7; i++) begin
            set_dir(vt[i].cw);
            detent(vt[i].bus, vt[i].mv);
        end

        // Walk up to the top position, then one more CW
        do_reset(3);
        set_dir(1'b1);
        for (int k = 1; k < 11; k++) begin
            detent(11'd1 << k, 1'b1);
        end
`ifdef ROTARY_WRAP_EN
        detent(11'h001, 1'b1);
`else
        detent(11'h400, 1'b0);
`endif

        // Short glitches on A are rejected, a stable low gives one step
        do_reset(2);
        for (int g = 0; g < 10; g++) begin
            enc_a = 1'b0;
            tick(3);
            enc_a = 1'b1;
            tick(3);
        end
        check("glitch_bus", 32'(rotary_bus), 32'h001);
        detent(11'h002, 1'b1);

        // Press and step in the same cycle; release gives no strobe
        enc_sw = 1'b0;
        enc_a  = 1'b0;
        mv_q.push_back('{11'h004, cyc + LAT});
        sw_q.push_back(cyc + LAT);
        tick(10);
        enc_a = 1'b1;
        tick(10);
        enc_sw = 1'b1;
        tick(25);
        check("press_bus", 32'(rotary_bus), 32'h004);

        // Reset while A is mid-debounce at position 5
        do_reset(2);
        for (int k = 1; k < 6; k++) begin
            detent(11'd1 << k, 1'b1);
        end
        enc_a = 1'b0;
        tick(3);
        rst_n = 1'b0;
        enc_a = 1'b1;
        tick(1);
        check("midrst_bus", 32'(rotary_bus), 32'h001);
        rst_n = 1'b1;
        tick(30);
        check("post_rst_bus", 32'(rotary_bus), 32'h001);
        detent(11'h002, 1'b1);

        tick(5);
        check("pending_moved", 32'(mv_q.size()), 32'd0);
        check("pending_press", 32'(sw_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
